hamming_secded_encoder_pipe: RTL and testbench

Parametrised successor to the fixed 64-bit Hamming encoder. It generates a Hamming code for any data width, with an optional overall-parity bit for SECDED. The datapath is a 2-stage pipeline with valid/ready handshakes on both sides. It adds a one-shot error-injection port and an encoded-word counter for decoder verification. It sits between the write-data source and the memory/link interface.

---
 rtl/hamming_secded_encoder_pipe.sv | 144 ++++++++++++++
 tb/tb_hamming_secded_encoder_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_encoder_pipe.sv
// Parametrised Hamming / SECDED encoder with a 2-stage valid/ready pipeline,
// a one-shot XOR error-injection port and a delivered-word counter.
module hamming_secded_encoder_pipe #(
   parameter int DATA_W  = 64,
   parameter int SECDED  = 1,
   parameter int COUNT_W = 16,
   // smallest P with 2^P >= DATA_W+P+1
   localparam int P = (DATA_W + 4  <= 8)    ? 3  :
                      (DATA_W + 5  <= 16)   ? 4  :
                      (DATA_W + 6  <= 32)   ? 5  :
                      (DATA_W + 7  <= 64)   ? 6  :
                      (DATA_W + 8  <= 128)  ? 7  :
                      (DATA_W + 9  <= 256)  ? 8  :
                      (DATA_W + 10 <= 512)  ? 9  :
                      (DATA_W + 11 <= 1024) ? 10 :
                      (DATA_W + 12 <= 2048) ? 11 : 12,
   localparam int N      = DATA_W + P,
   localparam int CODE_W = N + SECDED
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CODE_W-1:0]  out_code,
   input  logic               inj_arm,
   input  logic [CODE_W-1:0]  inj_mask,
   output logic               inj_pending,
   output logic [COUNT_W-1:0] word_count
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [P-1:0]      par;
   } s1_t;

   // 1-based code position of data bit j (j-th non-power-of-2 position)
   function automatic int data_pos(input int j);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int k = 1; k <= N; k++) begin
         if ((k & (k - 1)) != 0) begin
            if (cnt == j) pos = k;
            cnt++;
         end
      end
      return pos;
   endfunction

   logic               s1_valid_q, s1_valid_d;
   s1_t                s1_q, s1_d;
   logic               s2_valid_q, s2_valid_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic [CODE_W-1:0]  mask_q, mask_d;
   logic               inj_pending_q, inj_pending_d;
   logic [COUNT_W-1:0] word_count_q, word_count_d;

   logic               s2_adv, s1_adv, in_fire, out_fire;
   logic [P-1:0]       par_c;
   logic [N-1:0]       code_n;
   logic [CODE_W-1:0]  enc;

   always_comb begin
      s2_adv   = ~s2_valid_q | out_ready;
      s1_adv   = s1_valid_q & s2_adv;
      in_ready = enable & ~rst & (~s1_valid_q | s2_adv);
      in_fire  = in_valid & in_ready;
      out_fire = s2_valid_q & out_ready;
   end

   always_comb begin
      par_c = '0;
      for (int j = 0; j < DATA_W; j++)
         for (int i = 0; i < P; i++)
            if (((data_pos(j) >> i) & 1) != 0) par_c[i] = par_c[i] ^ in_data[j];
   end

   always_comb begin
      code_n = '0;
      for (int i = 0; i < P; i++) code_n[(1 << i) - 1] = s1_q.par[i];
      for (int j = 0; j < DATA_W; j++) code_n[data_pos(j) - 1] = s1_q.data[j];
      enc = CODE_W'(code_n);
      // overall parity covers the clean word so the mask shows up as a real error
      if (SECDED != 0) enc[CODE_W-1] = ^code_n;
   end

   always_comb begin
      s1_valid_d = in_fire | (s1_valid_q & ~s1_adv);
      s1_d       = s1_q;
      if (in_fire) begin
         s1_d.data = in_data;
         s1_d.par  = par_c;
      end

      s2_valid_d = s1_adv | (s2_valid_q & ~out_ready);
      code_d     = code_q;
      if (s1_adv) code_d = enc ^ (inj_pending_q ? mask_q : '0);

      // a new arm in the load cycle wins: old mask used now, new one stays pending
      inj_pending_d = inj_pending_q;
      mask_d        = mask_q;
      if (s1_adv) inj_pending_d = 1'b0;
      if (inj_arm) begin
         inj_pending_d = 1'b1;
         mask_d        = inj_mask;
      end

      word_count_d = word_count_q;
      if (out_fire) word_count_d = word_count_q + COUNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q    <= 1'b0;
         s2_valid_q    <= 1'b0;
         code_q        <= '0;
         mask_q        <= '0;
         inj_pending_q <= 1'b0;
         word_count_q  <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s2_valid_q    <= s2_valid_d;
         code_q        <= code_d;
         mask_q        <= mask_d;
         inj_pending_q <= inj_pending_d;
         word_count_q  <= word_count_d;
      end
   end

   always_ff @(posedge clk) begin
      s1_q <= s1_d;
   end

   assign out_valid   = s2_valid_q;
   assign out_code    = code_q;
   assign inj_pending = inj_pending_q;
   assign word_count  = word_count_q;

endmodule

// File: tb/tb_hamming_secded_encoder_pipe.sv
// Scoreboard bench: a 64-bit SECDED instance and an 8-bit / 4-bit-counter instance.
module tb_hamming_secded_encoder_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        en_a, iv_a, ir_a, ov_a, or_a, arm_a, pend_a;
   logic [63:0] id_a;
   logic [71:0] oc_a, mask_a;
   logic [15:0] wc_a;

   logic        en_b, iv_b, ir_b, ov_b, or_b, arm_b, pend_b;
   logic [7:0]  id_b;
   logic [12:0] oc_b, mask_b;
   logic [3:0]  wc_b;

   hamming_secded_encoder_pipe #(.DATA_W(64), .SECDED(1), .COUNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .enable(en_a), .in_valid(iv_a), .in_ready(ir_a),
      .in_data(id_a), .out_valid(ov_a), .out_ready(or_a), .out_code(oc_a),
      .inj_arm(arm_a), .inj_mask(mask_a), .inj_pending(pend_a), .word_count(wc_a));

   hamming_secded_encoder_pipe #(.DATA_W(8), .SECDED(1), .COUNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .enable(en_b), .in_valid(iv_b), .in_ready(ir_b),
      .in_data(id_b), .out_valid(ov_b), .out_ready(or_b), .out_code(oc_b),
      .inj_arm(arm_b), .inj_mask(mask_b), .inj_pending(pend_b), .word_count(wc_b));

   int n_chk  = 0;
   int n_fail = 0;
   logic [71:0] q_a[$];
   logic [12:0] q_b[$];
   bit rand_ready = 1'b0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // independent model: place data, then each parity = XOR of positions with bit i set
   function automatic logic [71:0] ref_code(input logic [63:0] d, input int dw);
      int p, n, idx;
      logic [71:0] c;
      logic par;
      p = 1;
      while ((1 << p) < dw + p + 1) p++;
      n = dw + p;
      c = '0;
      idx = 0;
      for (int k = 1; k <= n; k++)
         if ((k & (k - 1)) != 0) begin
            c[k-1] = d[idx];
            idx++;
         end
      for (int i = 0; i < p; i++) begin
         par = 1'b0;
         for (int k = 1; k <= n; k++)
            if (((k >> i) & 1) == 1) par = par ^ c[k-1];
         c[(1 << i) - 1] = par;
      end
      c[n] = ^c;
      return c;
   endfunction

   initial begin : mon_a
      bit hold;
      logic [71:0] held, e;
      hold = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst) hold = 1'b0;
         else begin
            if (hold) begin
               check("hold_valid_a", 72'(ov_a), 72'(1));
               check("hold_code_a", oc_a, held);
            end
            if (ov_a && or_a) begin
               if (q_a.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_a: got %h, expected no word", oc_a);
               end else begin
                  e = q_a.pop_front();
                  check("code_a", oc_a, e);
               end
            end
            hold = ov_a & ~or_a;
            held = oc_a;
         end
      end
   end

   initial begin : mon_b
      bit hold;
      logic [12:0] held, e;
      hold = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst) hold = 1'b0;
         else begin
            if (hold) begin
               check("hold_valid_b", 72'(ov_b), 72'(1));
               check("hold_code_b", 72'(oc_b), 72'(held));
            end
            if (ov_b && or_b) begin
               if (q_b.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_b: got %h, expected no word", oc_b);
               end else begin
                  e = q_b.pop_front();
                  check("code_b", 72'(oc_b), 72'(e));
               end
            end
            hold = ov_b & ~or_b;
            held = oc_b;
         end
      end
   end

   initial begin : ready_drv
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) or_a = 1'($urandom_range(0, 1));
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic send_a(input logic [63:0] d, input logic [71:0] e);
      int t;
      t = 0;
      iv_a = 1'b1;
      id_a = d;
      forever begin
         @(negedge clk);
         if (ir_a) begin
            q_a.push_back(e);
            break;
         end
         t++;
         if (t > 1000) begin
            n_chk++; n_fail++;
            $display("FAIL send_a_timeout: got in_ready=0, expected in_ready within 1000 cycles");
            break;
         end
      end
      @(posedge clk);
      #1;
      iv_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] d, input logic [12:0] e);
      int t;
      t = 0;
      iv_b = 1'b1;
      id_b = d;
      forever begin
         @(negedge clk);
         if (ir_b) begin
            q_b.push_back(e);
            break;
         end
         t++;
         if (t > 1000) begin
            n_chk++; n_fail++;
            $display("FAIL send_b_timeout: got in_ready=0, expected in_ready within 1000 cycles");
            break;
         end
      end
      @(posedge clk);
      #1;
      iv_b = 1'b0;
   endtask

   task automatic drain_a();
      int t;
      for (t = 0; t < 500; t++) begin
         @(posedge clk);
         #1;
         if (q_a.size() == 0 && !ov_a) break;
      end
      check("drain_a_left", 72'(q_a.size()), 72'(0));
   endtask

   task automatic drain_b();
      int t;
      for (t = 0; t < 500; t++) begin
         @(posedge clk);
         #1;
         if (q_b.size() == 0 && !ov_b) break;
      end
      check("drain_b_left", 72'(q_b.size()), 72'(0));
   endtask

   task automatic arm_inj_a(input logic [71:0] m);
      arm_a  = 1'b1;
      mask_a = m;
      @(posedge clk);
      #1;
      arm_a  = 1'b0;
   endtask

   initial begin : stim
      logic [63:0] d;
      logic [7:0]  db;
      rst = 1'b1;
      en_a = 1'b1; iv_a = 1'b0; id_a = '0; or_a = 1'b1; arm_a = 1'b0; mask_a = '0;
      en_b = 1'b1; iv_b = 1'b0; id_b = '0; or_b = 1'b1; arm_b = 1'b0; mask_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("in_ready_during_rst_a", 72'(ir_a), 72'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid_a", 72'(ov_a), 72'(0));
      check("rst_out_code_a", oc_a, 72'(0));
      check("rst_pending_a", 72'(pend_a), 72'(0));
      check("rst_count_a", 72'(wc_a), 72'(0));
      check("rst_in_ready_a", 72'(ir_a), 72'(1));
      check("rst_out_valid_b", 72'(ov_b), 72'(0));
      check("rst_count_b", 72'(wc_b), 72'(0));
      @(posedge clk);
      #1;

      // directed vectors and 2-cycle latency
      send_a(64'h0, 72'h0);
      @(negedge clk);
      check("latency_c1_valid_a", 72'(ov_a), 72'(0));
      @(negedge clk);
      check("latency_c2_valid_a", 72'(ov_a), 72'(1));
      @(posedge clk);
      #1;
      send_a(64'h1, 72'h80_0000_0000_0000_0007);
      drain_a();

      // injection: single-bit mask, then clean follower
      arm_inj_a(72'h1 << 5);
      @(negedge clk);
      check("inj_pending_armed", 72'(pend_a), 72'(1));
      @(posedge clk);
      #1;
      send_a(64'h1, 72'h80_0000_0000_0000_0027);
      send_a(64'h1, 72'h80_0000_0000_0000_0007);
      drain_a();
      check("inj_pending_cleared", 72'(pend_a), 72'(0));

      // overwrite while pending, then re-arm in the load cycle
      arm_inj_a(72'h1);
      arm_inj_a(72'h4);
      send_a(64'h1, 72'h80_0000_0000_0000_0003);
      arm_inj_a(72'h2);
      @(negedge clk);
      check("inj_rearm_pending", 72'(pend_a), 72'(1));
      @(posedge clk);
      #1;
      send_a(64'h1, 72'h80_0000_0000_0000_0005);
      drain_a();
      check("inj_rearm_cleared", 72'(pend_a), 72'(0));

      // reset with both stages full and downstream stalled
      or_a = 1'b0;
      send_a(64'hDEAD_BEEF_0123_4567, 72'h0);
      send_a(64'hFFFF_FFFF_FFFF_FFFF, 72'h0);
      arm_inj_a(72'h8);
      @(negedge clk);
      check("full_in_ready_a", 72'(ir_a), 72'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      q_a.delete();
      @(negedge clk);
      check("midrst_in_ready_a", 72'(ir_a), 72'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      or_a = 1'b1;
      @(negedge clk);
      check("midrst_out_valid_a", 72'(ov_a), 72'(0));
      check("midrst_count_a", 72'(wc_a), 72'(0));
      check("midrst_pending_a", 72'(pend_a), 72'(0));
      check("midrst_in_ready_a", 72'(ir_a), 72'(1));
      repeat (5) @(posedge clk);
      #1;

      // random stream with random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         d = {$urandom, $urandom};
         send_a(d, ref_code(d, 64));
      end
      rand_ready = 1'b0;
      or_a = 1'b1;
      drain_a();
      check("stream_count_a", 72'(wc_a), 72'(100));

      // 8-bit instance: directed vectors
      send_b(8'hFF, 13'h0F77);
      send_b(8'h00, 13'h0000);
      drain_b();

      // enable=0 with two words in flight
      or_b = 1'b0;
      send_b(8'h5A, 13'(ref_code(64'h5A, 8)));
      send_b(8'hA5, 13'(ref_code(64'hA5, 8)));
      en_b = 1'b0;
      iv_b = 1'b1;
      id_b = 8'h33;
      @(negedge clk);
      check("disabled_in_ready_b", 72'(ir_b), 72'(0));
      @(posedge clk);
      #1 or_b = 1'b1;
      @(negedge clk);
      check("disabled_drain_in_ready_b", 72'(ir_b), 72'(0));
      drain_b();
      repeat (3) @(posedge clk);
      #1;
      check("disabled_count_b", 72'(wc_b), 72'(4));
      iv_b = 1'b0;
      en_b = 1'b1;

      // counter wrap: 17 words total
      for (int i = 0; i < 13; i++) begin
         db = 8'($urandom);
         send_b(db, 13'(ref_code(64'(db), 8)));
      end
      drain_b();
      check("wrap_count_b", 72'(wc_b), 72'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
